pyramid_frame_buffer: RTL and testbench

PYRAMID_FRAME_BUFFER -- requirements
Module: pyramid_frame_buffer

---
 rtl/pyramid_pkg.sv | 20 ++
 rtl/frame_ram.sv | 36 +++
 rtl/pyramid_frame_buffer.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_pyramid_frame_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pyramid_pkg.sv
// Shared types and Q8.8 fixed-point helpers for the pyramid frame buffer.
package pyramid_pkg;

  // Top-level operating phases: fill the frame, scan the pyramid, hold the result.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Fractional bits of the Q8.8 source-coordinate accumulators.
  localparam int FRAC_W = 8;
  localparam int ONE_Q  = 1 << FRAC_W;

  // Source step per destination pixel at a given pyramid level (Q8.8).
  function automatic int step_for_level(input int level, input int scale_inc);
    return ONE_Q + level * scale_inc;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: synchronous write, one-cycle registered read.
module frame_ram
  import pyramid_pkg::*;
#(
  parameter int PIX_W  = 1,
  parameter int DEPTH  = 307200,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  // NOTE: the array has no reset so it can map onto block RAM; contents are only meaningful after a fill.
  logic [PIX_W-1:0] mem [DEPTH];

  // Write port: one pixel per strobe.
  // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: data appears the cycle after re; holds while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pyramid_frame_buffer.sv
// Frame buffer that stores one image in raster order, then streams it out as a
// pyramid of progressively downscaled levels (nearest-neighbour, Q8.8 stepping)
// over a valid/ready interface. A face_found input aborts the scan early.
module pyramid_frame_buffer
  import pyramid_pkg::*;
#(
  parameter int  PIX_W      = 1,
  parameter int  IMG_W      = 640,
  parameter int  IMG_H      = 480,
  parameter int  NUM_SCALES = 8,
  parameter int  SCALE_INC  = 64,
  localparam int ADDR_W     = $clog2(IMG_W * IMG_H),
  localparam int XW         = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW         = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int SW         = (NUM_SCALES > 1) ? $clog2(NUM_SCALES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PIX_W-1:0]  data_in,
  output logic [ADDR_W-1:0] writeAddr,
  output logic              RAM_full,
  input  logic              en,
  input  logic              face_found,
  input  logic              rearm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  data_out,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic [SW-1:0]     scale,
  output logic              end_scale,
  output logic              done,
  output logic              found
);

  localparam int NPIX     = IMG_W * IMG_H;
  // The fill counter needs one extra code so it can represent "all pixels written".
  localparam int CNT_W    = $clog2(NPIX + 1);
  localparam int MAX_STEP = step_for_level(NUM_SCALES - 1, SCALE_INC);
  localparam int STEP_W   = $clog2(MAX_STEP + 1);
  // Accumulators must hold the first out-of-range value before it is rejected.
  localparam int ACCX_W   = $clog2((IMG_W << FRAC_W) + MAX_STEP + 1);
  localparam int ACCY_W   = $clog2((IMG_H << FRAC_W) + MAX_STEP + 1);

  localparam logic [ACCX_W-1:0] X_LIMIT    = ACCX_W'(IMG_W << FRAC_W);
  localparam logic [ACCY_W-1:0] Y_LIMIT    = ACCY_W'(IMG_H << FRAC_W);
  localparam logic [ADDR_W-1:0] ROW_PITCH  = ADDR_W'(IMG_W);
  localparam logic [CNT_W-1:0]  LAST_WR    = CNT_W'(NPIX - 1);
  localparam logic [STEP_W-1:0] STEP0      = STEP_W'(step_for_level(0, SCALE_INC));
  localparam logic [STEP_W-1:0] STEP_INC   = STEP_W'(SCALE_INC);
  localparam logic [SW-1:0]     LAST_SCALE = SW'(NUM_SCALES - 1);

  // Control state.
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                ram_full_q, ram_full_d;
  logic                found_q, found_d;
  logic [SW-1:0]       scale_q, scale_d;
  logic [STEP_W-1:0]   step_q, step_d;

  // Issue stage: walks the current level in destination order.
  logic                issue_q, issue_d;
  logic [ACCX_W-1:0]   acc_x_q, acc_x_d;
  logic [ACCY_W-1:0]   acc_y_q, acc_y_d;
  logic [XW-1:0]       dx_q, dx_d;
  logic [YW-1:0]       dy_q, dy_d;

  // Read stage: tags for the pixel currently inside the RAM read register.
  logic                r_valid_q, r_valid_d;
  logic [XW-1:0]       r_x_q, r_x_d;
  logic [YW-1:0]       r_y_q, r_y_d;
  logic                r_last_q, r_last_d;

  // Output stage.
  logic                out_valid_q, out_valid_d;
  logic [PIX_W-1:0]    data_out_q, data_out_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic                last_q, last_d;
  logic                end_scale_q, end_scale_d;

  // Datapath helpers.
  logic [XW-1:0]       src_x;
  logic [YW-1:0]       src_y;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ACCX_W-1:0]   nx_acc_x;
  logic [ACCY_W-1:0]   nx_acc_y;
  logic                row_end, lvl_end;
  logic                advance, beat, ram_we, rd_en;
  logic [PIX_W-1:0]    rd_data;

  frame_ram #(
    .PIX_W  (PIX_W),
    .DEPTH  (NPIX),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_cnt_q[ADDR_W-1:0]),
    .wr_data (data_in),
    .re      (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Source coordinate, read address and pipeline handshake decode.
  always_comb begin
    src_x    = acc_x_q[FRAC_W +: XW];
    src_y    = acc_y_q[FRAC_W +: YW];
    rd_addr  = ADDR_W'(src_y) * ROW_PITCH + ADDR_W'(src_x);
    nx_acc_x = acc_x_q + ACCX_W'(step_q);
    nx_acc_y = acc_y_q + ACCY_W'(step_q);
    row_end  = nx_acc_x >= X_LIMIT;
    lvl_end  = row_end && (nx_acc_y >= Y_LIMIT);
    // The whole pipeline moves only when the output slot is empty or being taken.
    advance  = !out_valid_q || out_ready;
    beat     = out_valid_q && out_ready;
    ram_we   = (state_q == ST_FILL) && wr_en && !ram_full_q;
    rd_en    = (state_q == ST_SCAN) && issue_q && advance && !face_found;
  end

  // Next-state logic for the fill counter, scan pipeline and level sequencing.
  // NOTE: every signal starts from its held value so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    ram_full_d  = ram_full_q;
    found_d     = found_q;
    scale_d     = scale_q;
    step_d      = step_q;
    issue_d     = issue_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    r_valid_d   = r_valid_q;
    r_x_d       = r_x_q;
    r_y_d       = r_y_q;
    r_last_d    = r_last_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    x_d         = x_q;
    y_d         = y_q;
    last_d      = last_q;
    end_scale_d = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (ram_we) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_q == LAST_WR) begin
            ram_full_d = 1'b1;
          end
        end
        if (en && ram_full_q) begin
          state_d = ST_SCAN;
          scale_d = '0;
          step_d  = STEP0;
          issue_d = 1'b1;
          acc_x_d = '0;
          acc_y_d = '0;
          dx_d    = '0;
          dy_d    = '0;
        end
      end

      ST_SCAN: begin
        if (advance) begin
          out_valid_d = r_valid_q;
          if (r_valid_q) begin
            data_out_d = rd_data;
            x_d        = r_x_q;
            y_d        = r_y_q;
            last_d     = r_last_q;
          end
          r_valid_d = rd_en;
          r_x_d     = dx_q;
          r_y_d     = dy_q;
          r_last_d  = lvl_end;
          if (issue_q) begin
            if (row_end) begin
              acc_x_d = '0;
              dx_d    = '0;
              if (lvl_end) begin
                issue_d = 1'b0;
              end else begin
                acc_y_d = nx_acc_y;
                dy_d    = dy_q + YW'(1);
              end
            end else begin
              acc_x_d = nx_acc_x;
              dx_d    = dx_q + XW'(1);
            end
          end
        end

        if (face_found) begin
          // Abort wins over everything, including a simultaneous final beat.
          state_d     = ST_DONE;
          found_d     = 1'b1;
          out_valid_d = 1'b0;
          r_valid_d   = 1'b0;
          issue_d     = 1'b0;
          end_scale_d = beat && last_q;
        end else if (beat && last_q) begin
          end_scale_d = 1'b1;
          if (scale_q == LAST_SCALE) begin
            state_d = ST_DONE;
          end else begin
            scale_d = scale_q + SW'(1);
            step_d  = step_q + STEP_INC;
            issue_d = 1'b1;
            acc_x_d = '0;
            acc_y_d = '0;
            dx_d    = '0;
            dy_d    = '0;
          end
        end
      end

      ST_DONE: begin
        if (rearm) begin
          state_d    = ST_FILL;
          wr_cnt_d   = '0;
          ram_full_d = 1'b0;
          found_d    = 1'b0;
          scale_d    = '0;
        end
      end

      default: state_d = ST_FILL;
    endcase
  end

  // State registers with asynchronous reset to the empty-frame condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_cnt_q    <= '0;
      ram_full_q  <= 1'b0;
      found_q     <= 1'b0;
      scale_q     <= '0;
      step_q      <= STEP0;
      issue_q     <= 1'b0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      r_valid_q   <= 1'b0;
      r_x_q       <= '0;
      r_y_q       <= '0;
      r_last_q    <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      last_q      <= 1'b0;
      end_scale_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      ram_full_q  <= ram_full_d;
      found_q     <= found_d;
      scale_q     <= scale_d;
      step_q      <= step_d;
      issue_q     <= issue_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      r_valid_q   <= r_valid_d;
      r_x_q       <= r_x_d;
      r_y_q       <= r_y_d;
      r_last_q    <= r_last_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      x_q         <= x_d;
      y_q         <= y_d;
      last_q      <= last_d;
      end_scale_q <= end_scale_d;
    end
  end

  // When the frame size is a power of two the full count wraps to 0 on this
  // port; RAM_full distinguishes a full frame from an empty one.
  assign writeAddr = wr_cnt_q[ADDR_W-1:0];
  assign RAM_full  = ram_full_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign x         = x_q;
  assign y         = y_q;
  assign scale     = scale_q;
  assign end_scale = end_scale_q;
  assign done      = (state_q == ST_DONE);
  assign found     = found_q;

endmodule

// File: tb/tb_pyramid_frame_buffer.sv
// Self-checking bench for pyramid_frame_buffer on an 8x4 image with two levels.
module tb_pyramid_frame_buffer;

  localparam int PIX_W      = 1;
  localparam int IMG_W      = 8;
  localparam int IMG_H      = 4;
  localparam int NUM_SCALES = 2;
  localparam int SCALE_INC  = 256;
  localparam int ADDR_W     = $clog2(IMG_W * IMG_H);
  localparam int XW         = $clog2(IMG_W);
  localparam int YW         = $clog2(IMG_H);
  localparam int SW         = 1;
  localparam int NPIX       = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] FULL_ADDR = ADDR_W'(NPIX);

  logic              clk, rst, wr_en, en, face_found, rearm, out_ready;
  logic [PIX_W-1:0]  data_in, data_out;
  logic [ADDR_W-1:0] writeAddr;
  logic              RAM_full, out_valid, end_scale, done, found;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [SW-1:0]     scale;

  pyramid_frame_buffer #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .NUM_SCALES(NUM_SCALES), .SCALE_INC(SCALE_INC)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .writeAddr(writeAddr), .RAM_full(RAM_full), .en(en),
    .face_found(face_found), .rearm(rearm), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .x(x), .y(y),
    .scale(scale), .end_scale(end_scale), .done(done), .found(found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [PIX_W-1:0] d;
    int x;
    int y;
    int s;
    bit last;
  } beat_t;

  beat_t            exp_q[$];
  logic [PIX_W-1:0] img [NPIX];

  // Destination pixel n of a level samples source floor(n*step/256).
  function automatic void build_scan();
    beat_t b;
    exp_q.delete();
    for (int k = 0; k < NUM_SCALES; k++) begin
      int stp;
      stp = 256 + k * SCALE_INC;
      for (int dy = 0; (dy * stp) / 256 < IMG_H; dy++) begin
        for (int dx = 0; (dx * stp) / 256 < IMG_W; dx++) begin
          b.d    = img[((dy * stp) / 256) * IMG_W + (dx * stp) / 256];
          b.x    = dx;
          b.y    = dy;
          b.s    = k;
          b.last = 1'b0;
          exp_q.push_back(b);
        end
      end
      b = exp_q.pop_back();
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  // ---------------- output monitor ----------------
  bit          mon_en = 0;
  bit          prev_stall = 0;
  bit          prev_last = 0;
  bit          abort_pend = 0;
  int          n_es = 0;
  logic [31:0] held;

  always @(negedge clk) begin
    beat_t e;
    if (mon_en && !rst) begin
      if (abort_pend) begin
        check("abort_valid_drop", 32'(out_valid), 32'd0);
        exp_q.delete();
        abort_pend = 0;
        prev_stall = 0;
        prev_last  = 0;
      end else begin
        check("end_scale", 32'(end_scale), 32'(prev_last));
        if (end_scale) n_es++;
        prev_last = 0;
        if (prev_stall) begin
          check("stall_valid_hold", 32'(out_valid), 32'd1);
          check("stall_data_hold", 32'({data_out, x, y, scale}), held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got x=%0d y=%0d scale=%0d, expected no beat", x, y, scale);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(data_out), 32'(e.d));
            check("beat_x", 32'(x), 32'(e.x));
            check("beat_y", 32'(y), 32'(e.y));
            check("beat_scale", 32'(scale), 32'(e.s));
            prev_last = e.last;
          end
        end
        prev_stall = out_valid && !out_ready;
        held       = 32'({data_out, x, y, scale});
        if (face_found) abort_pend = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      data_in = PIX_W'((start + i) % 2);
      img[start + i] = data_in;
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_writeAddr"}, 32'(writeAddr), 32'd0);
    check({tag, "_RAM_full"}, 32'(RAM_full), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_scale"}, 32'(scale), 32'd0);
    check({tag, "_end_scale"}, 32'(end_scale), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_found"}, 32'(found), 32'd0);
  endtask

  // Launch a scan and confirm the two-cycle first-beat latency.
  task automatic start_scan();
    build_scan();
    prev_stall = 0;
    prev_last  = 0;
    abort_pend = 0;
    n_es       = 0;
    out_ready  = 1'b1;
    mon_en     = 1;
    en = 1'b1;
    step();
    en = 1'b0;
    check("lat_entry", 32'(out_valid), 32'd0);
    step();
    check("lat_plus1", 32'(out_valid), 32'd0);
    step();
    check("lat_plus2", 32'(out_valid), 32'd1);
  endtask

  task automatic run_to_done(input bit rand_ready, input bit wr_during);
    for (int c = 0; c < 400 && !done; c++) begin
      out_ready = (rand_ready && scale == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_en     = wr_during;
      data_in   = '1;
      step();
    end
    out_ready = 1'b1;
    wr_en     = 1'b0;
    check("done_reached", 32'(done), 32'd1);
    step();
    check("done_found", 32'(found), 32'd0);
    check("done_scale", 32'(scale), 32'(NUM_SCALES - 1));
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("end_scale_pulses", 32'(n_es), 32'(NUM_SCALES));
    mon_en = 0;
  endtask

  task automatic do_rearm(input string tag);
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    check({tag, "_writeAddr"}, 32'(writeAddr), 32'd0);
    check({tag, "_RAM_full"}, 32'(RAM_full), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_found"}, 32'(found), 32'd0);
    check({tag, "_scale"}, 32'(scale), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit hit;
    rst = 1'b1; wr_en = 1'b0; data_in = '0; en = 1'b0;
    face_found = 1'b0; rearm = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    rst = 1'b0;
    step();

    // Partial fill, then an early en that must be ignored.
    write_px(0, 10);
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("early_en_no_valid", 32'(out_valid), 32'd0);
    end
    check("early_en_addr", 32'(writeAddr), 32'd10);
    check("early_en_done", 32'(done), 32'd0);

    // Fill boundary: 31 pixels not full, 32nd sets full, 33rd ignored.
    write_px(10, 21);
    check("addr_31", 32'(writeAddr), 32'd31);
    check("full_31", 32'(RAM_full), 32'd0);
    write_px(31, 1);
    check("addr_32", 32'(writeAddr), 32'(FULL_ADDR));
    check("full_32", 32'(RAM_full), 32'd1);
    wr_en   = 1'b1;
    data_in = ~img[0];
    step();
    wr_en = 1'b0;
    check("addr_33", 32'(writeAddr), 32'(FULL_ADDR));
    check("full_33", 32'(RAM_full), 32'd1);

    // Pin the model with hand-derived values.
    build_scan();
    check("model_beats", 32'(exp_q.size()), 32'd40);
    check("model_l0_b5_data", 32'(exp_q[5].d), 32'd1);
    check("model_l0_last", 32'(exp_q[31].last), 32'd1);
    check("model_l1_b5_xy", 32'({exp_q[37].x[7:0], exp_q[37].y[7:0]}), 32'h0101);
    check("model_l1_b5_data", 32'(exp_q[37].d), 32'd0);

    // Full-rate scan with writes attempted during SCAN.
    start_scan();
    run_to_done(1'b0, 1'b1);
    check("scan_wr_addr", 32'(writeAddr), 32'(FULL_ADDR));
    do_rearm("rearm_a");

    // Backpressured scan.
    write_px(0, NPIX);
    start_scan();
    run_to_done(1'b1, 1'b0);
    do_rearm("rearm_b");

    // Abort on face_found at level 1, beat 3.
    write_px(0, NPIX);
    start_scan();
    hit = 0;
    for (int c = 0; c < 400; c++) begin
      if (out_valid && scale == 1 && x == 3 && y == 0) begin
        hit = 1;
        break;
      end
      step();
    end
    check("ff_target_reached", 32'(hit), 32'd1);
    face_found = 1'b1;
    step();
    face_found = 1'b0;
    check("ff_valid_drop", 32'(out_valid), 32'd0);
    check("ff_done", 32'(done), 32'd1);
    check("ff_found", 32'(found), 32'd1);
    step();
    mon_en = 0;
    do_rearm("rearm_c");

    // Asynchronous reset in the middle of level 0.
    write_px(0, NPIX);
    start_scan();
    repeat (10) step();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    mon_en = 0;
    #2 rst = 1'b1;
    #1 reset_checks("mid_rst");
    step();
    rst = 1'b0;
    step();

    // Refill and rescan must reproduce the full-rate result.
    write_px(0, NPIX);
    start_scan();
    run_to_done(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
